// File: rtl/seg7_scan_display_if.sv
// Bundle of the load/value/status and display pin signals of the seven-segment scan driver.
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    Load;
  logic [4*NUM_DIGITS-1:0] Value;
  logic                    DecMode;
  logic                    BlankLZ;
  logic                    Busy;
  logic [6:0]              out7;
  logic [NUM_DIGITS-1:0]   en_out;

  modport master (
    output Load, Value, DecMode, BlankLZ,
    input  Busy, out7, en_out
  );

  modport slave (
    input  Load, Value, DecMode, BlankLZ,
    output Busy, out7, en_out
  );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver: captures a value on Load, optionally converts it
// to decimal with a sequential double-dabble engine, blanks leading zeros on request
// and scans NUM_DIGITS digits with registered segment/enable outputs.
//
// state | meaning
// IDLE  | waiting for Load; hex values go straight to the display register
// CONV  | one double-dabble step per cycle; Busy high, further Loads dropped
module seg7_scan_display #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic Clk,
  input logic Reset,
  seg7_scan_display_if.slave bus
);
  localparam int W      = 4 * NUM_DIGITS;
  localparam int BCD_D  = NUM_DIGITS + NUM_DIGITS / 4 + 1;
  localparam int BW     = 4 * BCD_D;
  localparam int STEP_W = $clog2(W);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t state, state_nxt;

  logic                  busy, hex_load, dec_start, commit, last_step;
  logic [W-1:0]          shift_q, shift_nxt;
  logic [BW-1:0]         bcd_q, bcd_adj, bcd_nxt;
  logic [STEP_W-1:0]     step_q;
  logic                  blank_pend_q;
  logic [W-1:0]          disp_q;
  logic                  blank_q, ovf_q;
  logic [CNT_W-1:0]      refresh_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      msd;
  logic [3:0]            digit;
  logic                  lit;
  logic [6:0]            seg_on;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            out7_q;
  logic [NUM_DIGITS-1:0] en_q;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'h3F;
      4'h1: seg_code = 7'h06;
      4'h2: seg_code = 7'h5B;
      4'h3: seg_code = 7'h4F;
      4'h4: seg_code = 7'h66;
      4'h5: seg_code = 7'h6D;
      4'h6: seg_code = 7'h7D;
      4'h7: seg_code = 7'h07;
      4'h8: seg_code = 7'h7F;
      4'h9: seg_code = 7'h6F;
      4'hA: seg_code = 7'h77;
      4'hB: seg_code = 7'h7C;
      4'hC: seg_code = 7'h39;
      4'hD: seg_code = 7'h5E;
      4'hE: seg_code = 7'h79;
      default: seg_code = 7'h71;
    endcase
  endfunction

  assign last_step = (step_q == '0);

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.Load && bus.DecMode) state_nxt = CONV;
      CONV: if (last_step)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: status and datapath strobes
  always_comb begin
    busy      = (state == CONV);
    hex_load  = (state == IDLE) && bus.Load && !bus.DecMode;
    dec_start = (state == IDLE) && bus.Load && bus.DecMode;
    commit    = (state == CONV) && last_step;
  end

  assign bus.Busy = busy;

  // One double-dabble step: add 3 to every digit >= 5, then shift the pair left
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_nxt   = BW'({bcd_adj, shift_q[W-1]});
    shift_nxt = {shift_q[W-2:0], 1'b0};
  end

  // Conversion engine registers; step counter runs down to the terminal step
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shift_q      <= '0;
      bcd_q        <= '0;
      step_q       <= '0;
      blank_pend_q <= 1'b0;
    end else if (dec_start) begin
      shift_q      <= bus.Value;
      bcd_q        <= '0;
      step_q       <= STEP_W'(W - 1);
      blank_pend_q <= bus.BlankLZ;
    end else if (busy) begin
      shift_q <= shift_nxt;
      bcd_q   <= bcd_nxt;
      step_q  <= step_q - 1'b1;
    end
  end

  // Display register: only complete values are ever written
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_q  <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (hex_load) begin
      disp_q  <= bus.Value;
      blank_q <= bus.BlankLZ;
      ovf_q   <= 1'b0;
    end else if (commit) begin
      disp_q  <= bcd_nxt[W-1:0];
      blank_q <= blank_pend_q;
      ovf_q   <= |bcd_nxt[BW-1:W];
    end
  end

  // Refresh counter and scan index
  always_ff @(posedge Clk) begin
    if (Reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Current digit, most significant nonzero digit and lit decision
  always_comb begin
    digit = 4'h0;
    msd   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i))        digit = disp_q[4*i +: 4];
      if (disp_q[4*i +: 4] != 4'h0)  msd   = IDX_W'(i);
    end
    lit    = !blank_q || ovf_q || (idx_q <= msd);
    seg_on = ovf_q ? 7'h40 : seg_code(digit);
    onehot = NUM_DIGITS'(1) << idx_q;
  end

  // Output registers; blanked digits drive everything off
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out7_q <= {7{ACTIVE_LOW}};
      en_q   <= {NUM_DIGITS{ACTIVE_LOW}};
    end else if (lit) begin
      out7_q <= seg_on ^ {7{ACTIVE_LOW}};
      en_q   <= onehot ^ {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      out7_q <= {7{ACTIVE_LOW}};
      en_q   <= {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

  assign bus.out7   = out7_q;
  assign bus.en_out = en_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomised bench for seg7_scan_display against an arithmetic reference model.
module tb_seg7_scan_display;
  localparam int ND = 8;
  localparam int RD = 4;

  logic Clk = 1'b0;
  logic Reset;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   edges  = 0;

  logic [31:0] m_val;
  bit          m_dec, m_blank;

  seg7_scan_display_if #(.NUM_DIGITS(ND)) bus();

  seg7_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Edges since reset release; drives the expected scan position
  always @(posedge Clk) begin
    if (Reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Expected {en_out, out7} when scan position idx is displayed
  function automatic logic [14:0] model_out(input int idx);
    longint v;
    longint p;
    int     dig[ND];
    int     msd;
    bit     ovf, lit;
    logic [6:0] seg;
    logic [7:0] en;
    v   = longint'(m_val);
    ovf = m_dec && (v > 64'd99999999);
    p   = 1;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      dig[i] = m_dec ? int'((v / p) % 10) : int'((v >> (4 * i)) & 15);
      p = p * 10;
      if (dig[i] != 0) msd = i;
    end
    lit = !m_blank || ovf || (idx <= msd);
    seg = ovf ? 7'h40 : glyph(dig[idx]);
    en  = 8'(1) << idx;
    if (lit) return {~en, ~seg};
    return {8'hFF, 7'h7F};
  endfunction

  task automatic check_scan(input int n);
    logic [14:0] e;
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = ((edges - 1) / RD) % ND;
      e = model_out(idx);
      chk("en_out", 32'(bus.en_out), 32'(e[14:7]));
      chk("out7", 32'(bus.out7), 32'(e[6:0]));
      @(negedge Clk);
    end
  endtask

  // Called at a negedge; optional extra Load at busy cycle extra_at, Reset at rst_at
  task automatic run_load(input logic [31:0] v, input bit dec, input bit blank,
                          input int extra_at, input int rst_at);
    int busy_cnt;
    bit aborted;
    busy_cnt = 0;
    aborted  = 1'b0;
    bus.Value   = v;
    bus.DecMode = dec;
    bus.BlankLZ = blank;
    bus.Load    = 1'b1;
    @(negedge Clk);
    bus.Load = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (!bus.Busy) break;
      busy_cnt++;
      if (k == extra_at) begin
        bus.Value   = 32'd99;
        bus.DecMode = 1'b1;
        bus.Load    = 1'b1;
      end
      if (k == rst_at) Reset = 1'b1;
      @(negedge Clk);
      bus.Load = 1'b0;
      if (Reset) begin
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_out7", 32'(bus.out7), 32'h7F);
        chk("rst_en", 32'(bus.en_out), 32'hFF);
        Reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      m_val = 32'd0; m_dec = 1'b0; m_blank = 1'b0;
    end else begin
      chk("busy_len", 32'(busy_cnt), dec ? 32'd32 : 32'd0);
      m_val = v; m_dec = dec; m_blank = blank;
    end
    @(negedge Clk);
    check_scan(ND * RD + 8);
  endtask

  initial begin
    logic [31:0] rv;
    Reset = 1'b1;
    bus.Load = 1'b0; bus.Value = '0; bus.DecMode = 1'b0; bus.BlankLZ = 1'b0;
    m_val = 32'd0; m_dec = 1'b0; m_blank = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_out7", 32'(bus.out7), 32'h7F);
    chk("reset_en", 32'(bus.en_out), 32'hFF);
    Reset = 1'b0;
    @(negedge Clk);
    check_scan(ND * RD + 4);

    run_load(32'h1234ABCD, 1'b0, 1'b0, 0, 0);
    run_load(32'd12345678, 1'b1, 1'b0, 0, 0);
    run_load(32'd100000000, 1'b1, 1'b0, 0, 0);
    run_load(32'd42, 1'b1, 1'b1, 0, 0);
    run_load(32'd0, 1'b1, 1'b1, 0, 0);
    run_load(32'h000000A0, 1'b0, 1'b1, 0, 0);
    run_load(32'd12345678, 1'b1, 1'b0, 5, 0);
    run_load(32'd87654321, 1'b1, 1'b0, 0, 10);
    run_load(32'd99999999, 1'b1, 1'b1, 0, 0);

    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: rv = $urandom;
        1: rv = $urandom_range(0, 99999999);
        2: rv = $urandom_range(0, 999);
        default: rv = 32'($urandom_range(0, 15)) << (4 * $urandom_range(0, 7));
      endcase
      run_load(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
